bcd_updown_counter: RTL and testbench
=====================================

# bcd_updown_counter

Parametrised multi-digit BCD up/down counter. It is the successor to the single-digit decade up/down counter, generalised to `DIGITS` cascaded decades. It adds a count enable, a parallel load with digit validation, and a registered wrap/terminal-count flag. It sits behind the button/debounce front end and drives the seven-segment display mux and any downstream cascade.

## Interface
Parameters:
- `DIGITS`, default 4: number of BCD decades; legal range 1..8; count width is `4*DIGITS`.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `en`  in  1  count enable; one step per cycle while high.
- `up`  in  1  direction: 1 counts up, 0 counts down; sampled only when `en` is high.
- `load`  in  1  parallel load strobe.
- `load_value`  in  `4*DIGITS`  BCD value to load; digit k occupies bits `[4k+3:4k]`.
- `count`  out  `4*DIGITS`  current BCD value; digit 0 is least significant.
- `tc`  out  1  registered one-cycle pulse on wrap (or on a saturation attempt).
- `load_err`  out  1  registered one-cycle pulse when a rejected load occurs.

## Operation
- Priority per cycle: `reset` > `load` > `en` > hold.
- Reset: `count` = all zeros, `tc` = 0, `load_err` = 0.
- Load:
  - Every digit of `load_value` ≤ 9: `count` ← `load_value`, `load_err` = 0.
  - Any digit > 9: `count` holds and `load_err` = 1 for one cycle. No partial load.
  - `tc` = 0 in a load cycle.
- Up step:
  - Digit 0 increments. A digit at 9 goes to 0 and carries into the next digit. The carry ripples combinationally within the cycle.
  - Digits above the first non-9 digit are unchanged.
- Down step:
  - Digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
- Wrap (macro absent):
  - Up from all 9s (e.g. 9999) → 0000 with `tc` = 1.
  - Down from 0000 → 9999 with `tc` = 1.
- `en` low and `load` low: `count` holds; `tc` and `load_err` = 0.
- `up` may change on any cycle. A direction change takes effect on the next enabled step. No extra latency.
- The count is always valid BCD; no reachable state has a digit > 9.
- No internal FSM beyond the counter register. The per-digit cell has 10 legal states, 0..9, with the transitions above.

## Timing
- All outputs are registered.
- `count`, `tc` and `load_err` reflect the inputs sampled at edge N after edge N. Latency is 1 cycle.
- `reset` asserted mid-count overrides `load` and `en` at that edge. The next cycle `count` = 0 and both flags = 0.
- `tc` and `load_err` are never asserted in the same cycle.
- Continuous `en`: one step per cycle. `tc` pulses exactly once per 10^DIGITS steps in wrap mode.

## Configuration
- `BCDCNT_SATURATE_EN` defined:
  - Counter saturates instead of wrapping.
  - Up at all 9s holds all 9s; down at 0000 holds 0000.
  - `tc` = 1 for each enabled cycle in which a step is attempted at the limit.
  - Load and all other behaviour are unchanged.
- `BCDCNT_SATURATE_EN` undefined: wrap behaviour as in Operation.
- Port list is identical in both builds.

## Structure
- Shared package `bcd_cnt_pkg`:
  - `bcd_digit_t` (4-bit digit type).
  - Constants `BCD_MAX` = 4'd9 and `BCD_MIN` = 4'd0.
  - Function `bcd_valid(digit)`.
- Sub-module `bcd_digit_cell`: one decade.
  - Inputs: current digit, step enable, direction.
  - Outputs: next digit and ripple carry/borrow, both combinational.
  - Instantiated `DIGITS` times via generate, chained on carry/borrow.
- Top level holds:
  - the count register;
  - load validation (AND over `bcd_valid` of all digits);
  - wrap/saturation detection;
  - the `tc` and `load_err` registers.

## Test plan
- Reset then up-count, `DIGITS`=4: reset high 1 cycle, then `en`=1 `up`=1 for 12 cycles → `count` steps 0000..0012. At 0009 → 0010 only digits 0 and 1 change; `tc` stays 0.
- Up wrap: load 9998, `en`=1 `up`=1 → 9999, then 0000 with `tc`=1 for exactly that cycle, then 0001 with `tc`=0. With `BCDCNT_SATURATE_EN`: 9999 holds and `tc`=1 on each attempt.
- Down borrow and wrap: load 1000, down 1 step → 0999. Load 0000, down 1 step → 9999 with `tc`=1 (saturate build: 0000 held, `tc`=1).
- Invalid load: `count`=0042, `load_value`=0x12A4 → `count` stays 0042 and `load_err`=1 for one cycle. Then `load_value`=0x0573 → `count`=0573, `load_err`=0.
- Priority and mid-operation reset: `load`=1 and `en`=1 in the same cycle → load wins. `reset`=1 with `load`=1 at `count`=0573 → 0000, flags 0.
- Hold and direction toggle: `en`=0 for 5 cycles → `count` unchanged. Toggle `up` every cycle with `en`=1 from 0500 → 0501, 0500, 0501, ...

Source files
------------

// File: rtl/bcd_cnt_pkg.sv
// Shared BCD types, limits and digit validation for the BCD counter family.
package bcd_cnt_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic bcd_valid(input bcd_digit_t digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD decade: combinational next digit plus ripple carry/borrow.
// The step input is the carry/borrow from the decade below (en for digit 0).
module bcd_digit_cell
  import bcd_cnt_pkg::*;
(
  input  bcd_digit_t digit_i,
  input  logic       step_i,
  input  logic       up_i,
  output bcd_digit_t digit_o,
  output logic       carry_o
);

  // Step the digit when asked; roll 9->0 (up) or 0->9 (down) and ripple on.
  always_comb begin
    digit_o = digit_i;
    carry_o = 1'b0;
    if (step_i) begin
      if (up_i) begin
        if (digit_i == BCD_MAX) begin
          digit_o = BCD_MIN;
          carry_o = 1'b1;
        end else begin
          digit_o = digit_i + 4'd1;
        end
      end else begin
        if (digit_i == BCD_MIN) begin
          digit_o = BCD_MAX;
          carry_o = 1'b1;
        end else begin
          digit_o = digit_i - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with enable, validated parallel load and a
// registered wrap/terminal-count pulse.
// Build option: define BCDCNT_SATURATE_EN to saturate at 0..99..9 instead of
// wrapping; tc then pulses on every step attempted at the limit.
module bcd_updown_counter
  import bcd_cnt_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  load_err
);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                tc_q, tc_d;
  logic                load_err_q, load_err_d;

  logic [DIGITS:0]     carry;
  logic [4*DIGITS-1:0] stepped;
  logic                load_ok;

  assign carry[0] = en;

  // Carry out of the top decade means every digit sat at the limit.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_cell u_cell (
      .digit_i (count_q[4*k +: 4]),
      .step_i  (carry[k]),
      .up_i    (up),
      .digit_o (stepped[4*k +: 4]),
      .carry_o (carry[k+1])
    );
  end

  // A load is accepted only if every digit is legal BCD (no partial load).
  always_comb begin
    load_ok = 1'b1;
    for (int k = 0; k < DIGITS; k++)
      load_ok = load_ok & bcd_valid(load_value[4*k +: 4]);
  end

  // Next state: load beats count-enable beats hold; flags default low.
  always_comb begin
    count_d    = count_q;
    tc_d       = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) count_d    = load_value;
      else         load_err_d = 1'b1;
    end else if (en) begin
`ifdef BCDCNT_SATURATE_EN
      if (carry[DIGITS]) tc_d    = 1'b1;
      else               count_d = stepped;
`else
      count_d = stepped;
      tc_d    = carry[DIGITS];
`endif
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q    <= '0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign tc       = tc_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: stimulus pushes expected results from an integer model,
// a monitor pops and compares one entry per clock.
module tb_bcd_updown_counter;

  localparam int D   = 4;
  localparam int MOD = 10000;

  logic          clock = 1'b0;
  logic          reset, en, up, load;
  logic [4*D-1:0] load_value;
  logic [4*D-1:0] count;
  logic          tc, load_err;

  typedef struct packed {
    logic [4*D-1:0] cnt;
    logic           tc;
    logic           lerr;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   mval  = 0;

  bcd_updown_counter #(.DIGITS(D)) dut (
    .clock(clock), .reset(reset), .en(en), .up(up), .load(load),
    .load_value(load_value), .count(count), .tc(tc), .load_err(load_err)
  );

  always #5 clock = ~clock;

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    int t;
    t = v;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Issue one cycle of stimulus and record what the counter must show after it.
  task automatic cycle(input logic r, input logic ld, input logic [4*D-1:0] lv,
                       input logic e, input logic u);
    exp_t x;
    int   v, p;
    logic ok;
    @(negedge clock);
    reset = r; load = ld; load_value = lv; en = e; up = u;
    x.tc = 1'b0; x.lerr = 1'b0;
    if (r) begin
      mval = 0;
    end else if (ld) begin
      ok = 1'b1; v = 0; p = 1;
      for (int k = 0; k < D; k++) begin
        if (lv[4*k +: 4] > 4'd9) ok = 1'b0;
        v = v + int'(lv[4*k +: 4]) * p;
        p = p * 10;
      end
      if (ok) mval = v;
      else    x.lerr = 1'b1;
    end else if (e) begin
      if (u) begin
        if (mval == MOD-1) begin
          x.tc = 1'b1;
`ifndef BCDCNT_SATURATE_EN
          mval = 0;
`endif
        end else mval = mval + 1;
      end else begin
        if (mval == 0) begin
          x.tc = 1'b1;
`ifndef BCDCNT_SATURATE_EN
          mval = MOD-1;
`endif
        end else mval = mval - 1;
      end
    end
    x.cnt = to_bcd(mval);
    q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [4*D-1:0] act, input logic [4*D-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry corresponds to each clock after stimulus.
  initial begin
    exp_t x;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("count", count, x.cnt);
        chk("tc", {15'd0, tc}, {15'd0, x.tc});
        chk("load_err", {15'd0, load_err}, {15'd0, x.lerr});
      end
    end
  end

  initial begin
    int sel;
    logic [4*D-1:0] lv;
    reset = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_value = '0;

    // reset then count up 12
    cycle(1, 0, '0, 0, 0);
    for (int i = 0; i < 12; i++) cycle(0, 0, '0, 1, 1);
    // up wrap from 9998
    cycle(0, 1, 16'h9998, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1, 1);
    // down borrow and down wrap
    cycle(0, 1, 16'h1000, 0, 0);
    cycle(0, 0, '0, 1, 0);
    cycle(0, 1, 16'h0000, 0, 0);
    cycle(0, 0, '0, 1, 0);
    cycle(0, 0, '0, 1, 0);
    // invalid load then valid load
    cycle(0, 1, 16'h0042, 0, 0);
    cycle(0, 1, 16'h12A4, 0, 0);
    cycle(0, 1, 16'h0573, 0, 0);
    // load beats enable, reset beats load
    cycle(0, 1, 16'h0811, 1, 1);
    cycle(0, 1, 16'h0573, 0, 0);
    cycle(1, 1, 16'h0573, 1, 1);
    // hold, then toggle direction every cycle
    cycle(0, 1, 16'h0500, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, '0, 0, $urandom_range(0, 1));
    for (int i = 0; i < 8; i++) cycle(0, 0, '0, 1, (i % 2 == 0));

    // randomized traffic with boundary-biased loads
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 2) begin
        cycle(1, $urandom_range(0, 1), 16'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));
      end else if (sel < 14) begin
        case ($urandom_range(0, 3))
          0: lv = to_bcd($urandom_range(0, MOD-1));
          1: lv = 16'($urandom);
          2: lv = 16'h9999 - 16'($urandom_range(0, 1));
          default: lv = 16'h0000 + 16'($urandom_range(0, 1));
        endcase
        cycle(0, 1, lv, $urandom_range(0, 1), $urandom_range(0, 1));
      end else if (sel < 85) begin
        cycle(0, 0, 16'($urandom), 1, $urandom_range(0, 1));
      end else begin
        cycle(0, 0, 16'($urandom), 0, $urandom_range(0, 1));
      end
    end

    // drain scoreboard with a bounded wait
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
    if (q.size() > 0) begin
      fails++;
      tests++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
